// File: rtl/addsub_seq_nbit.sv
// Multi-cycle signed/unsigned adder-subtractor for the calculator datapath.
// Works through the operands one SLICE_W-bit slice per clock, LSB slice first,
// and chains the carry between slices. Subtraction is done as a + ~b + 1.
// A valid/ready handshake is used on both the request and the result side.
module addsub_seq_nbit #(
   parameter int WIDTH   = 16,
   parameter int SLICE_W = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_mode,
   input  logic             i_cin,
   input  logic             i_use_cin,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_carry,
   output logic             o_ovf,
   output logic             o_zero,
   output logic             o_neg
);

   localparam int NSLICE = WIDTH / SLICE_W;
   localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t state;
   state_t next_state;

   logic [WIDTH-1:0]   a_reg;
   logic [WIDTH-1:0]   b_reg;
   logic [WIDTH-1:0]   sum_work;
   logic [WIDTH-1:0]   sum_reg;
   logic [WIDTH-1:0]   next_sum;
   logic               carry;
   logic               carry_flag;
   logic               ovf_flag;
   logic               zero_flag;
   logic [IDX_W-1:0]   idx;
   logic [SLICE_W-1:0] slice_a;
   logic [SLICE_W-1:0] slice_b;
   logic [SLICE_W-1:0] slice_sum;
   logic               slice_cout;
   logic               slice_cmsb;
   logic               accept;

   assign accept = i_valid && (state == IDLE);

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic: one RUN cycle per slice, then wait in DONE for the consumer
   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (accept) next_state = RUN;
         RUN:  if (idx == LAST_IDX) next_state = DONE;
         DONE: if (i_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Handshake outputs decoded from the current state
   always_comb begin
      o_ready = 1'b0;
      o_valid = 1'b0;
      case (state)
         IDLE:    o_ready = 1'b1;
         DONE:    o_valid = 1'b1;
         default: ;
      endcase
   end

   // Slice adder; the carry into the slice MSB is recovered as a ^ b ^ sum
   always_comb begin
      slice_a    = a_reg[int'(idx)*SLICE_W +: SLICE_W];
      slice_b    = b_reg[int'(idx)*SLICE_W +: SLICE_W];
      {slice_cout, slice_sum} = {1'b0, slice_a} + {1'b0, slice_b}
                              + (SLICE_W+1)'(carry);
      slice_cmsb = slice_a[SLICE_W-1] ^ slice_b[SLICE_W-1] ^ slice_sum[SLICE_W-1];
      next_sum   = sum_work;
      next_sum[int'(idx)*SLICE_W +: SLICE_W] = slice_sum;
   end

   // Operand capture, slice accumulation and result/flag commit on the last slice
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         a_reg      <= '0;
         b_reg      <= '0;
         sum_work   <= '0;
         sum_reg    <= '0;
         carry      <= 1'b0;
         carry_flag <= 1'b0;
         ovf_flag   <= 1'b0;
         zero_flag  <= 1'b0;
         idx        <= '0;
      end else if (accept) begin
         a_reg    <= i_a;
         b_reg    <= i_b ^ {WIDTH{i_mode}};
         carry    <= i_use_cin ? i_cin : i_mode;
         sum_work <= '0;
         idx      <= '0;
      end else if (state == RUN) begin
         sum_work <= next_sum;
         carry    <= slice_cout;
         if (idx == LAST_IDX) begin
            sum_reg    <= next_sum;
            carry_flag <= slice_cout;
            ovf_flag   <= slice_cout ^ slice_cmsb;
            zero_flag  <= (next_sum == '0);
         end else begin
            idx <= idx + 1'b1;
         end
      end
   end

   assign o_sum   = sum_reg;
   assign o_carry = carry_flag;
   assign o_ovf   = ovf_flag;
   assign o_zero  = zero_flag;
   assign o_neg   = sum_reg[WIDTH-1];

endmodule

// File: tb/tb_addsub_seq_nbit.sv
// Directed testbench for addsub_seq_nbit: a 16-bit/4-bit-slice instance and a
// single-slice 4-bit instance, both checked against hand-computed results.
module tb_addsub_seq_nbit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        res_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        mode;
   logic        cin;
   logic        use_cin;
   logic        dut_ready;
   logic        dut_valid;
   logic [15:0] sum;
   logic        carry;
   logic        ovf;
   logic        zero;
   logic        neg;

   logic        s_req_valid;
   logic        s_res_ready;
   logic [3:0]  s_a;
   logic [3:0]  s_b;
   logic        s_mode;
   logic        s_ready;
   logic        s_valid;
   logic [3:0]  s_sum;
   logic        s_carry;
   logic        s_ovf;
   logic        s_zero;
   logic        s_neg;

   int tests_run    = 0;
   int tests_failed = 0;
   int lat;

   // Free-running clock, period 10
   always #5 clk = ~clk;

   addsub_seq_nbit #(.WIDTH(16), .SLICE_W(4)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(req_valid), .o_ready(dut_ready),
      .i_a(a), .i_b(b), .i_mode(mode), .i_cin(cin), .i_use_cin(use_cin),
      .o_valid(dut_valid), .i_ready(res_ready), .o_sum(sum), .o_carry(carry),
      .o_ovf(ovf), .o_zero(zero), .o_neg(neg)
   );

   addsub_seq_nbit #(.WIDTH(4), .SLICE_W(4)) dut_small (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(s_req_valid), .o_ready(s_ready),
      .i_a(s_a), .i_b(s_b), .i_mode(s_mode), .i_cin(1'b0), .i_use_cin(1'b0),
      .o_valid(s_valid), .i_ready(s_res_ready), .o_sum(s_sum), .o_carry(s_carry),
      .o_ovf(s_ovf), .o_zero(s_zero), .o_neg(s_neg)
   );

   // Watchdog so the bench can never hang
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got timeout required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      tests_run++;
      if (observed !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Issue one request from IDLE and count cycles until o_valid is seen
   task automatic applyStimulus(input logic [15:0] a_v, input logic [15:0] b_v,
                                input logic mode_v, input logic cin_v,
                                input logic use_cin_v, output int cycles);
      @(negedge clk);
      checkOutput("ready_before_accept", 32'(dut_ready), 32'd1);
      a = a_v; b = b_v; mode = mode_v; cin = cin_v; use_cin = use_cin_v;
      req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      a = ~a_v; b = ~b_v; mode = ~mode_v; cin = ~cin_v;
      cycles = 0;
      while (!dut_valid && cycles < 20) begin
         @(posedge clk);
         cycles++;
         @(negedge clk);
      end
   endtask

   task automatic checkResult(input string tag, input logic [15:0] exp_sum,
                              input logic exp_c, input logic exp_o,
                              input logic exp_z, input logic exp_n,
                              input int cycles);
      checkOutput({tag, "_latency"}, 32'(cycles), 32'd4);
      checkOutput({tag, "_sum"},   32'(sum),   32'(exp_sum));
      checkOutput({tag, "_carry"}, 32'(carry), 32'(exp_c));
      checkOutput({tag, "_ovf"},   32'(ovf),   32'(exp_o));
      checkOutput({tag, "_zero"},  32'(zero),  32'(exp_z));
      checkOutput({tag, "_neg"},   32'(neg),   32'(exp_n));
   endtask

   // Complete the result handshake and confirm the result is still held in IDLE
   task automatic consumeResult(input string tag, input logic [15:0] exp_sum);
      res_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      res_ready = 1'b0;
      checkOutput({tag, "_valid_drop"}, 32'(dut_valid), 32'd0);
      checkOutput({tag, "_ready_back"}, 32'(dut_ready), 32'd1);
      checkOutput({tag, "_sum_held"},   32'(sum),       32'(exp_sum));
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; res_ready = 1'b0;
      a = '0; b = '0; mode = 1'b0; cin = 1'b0; use_cin = 1'b0;
      s_req_valid = 1'b0; s_res_ready = 1'b0; s_a = '0; s_b = '0; s_mode = 1'b0;

      #12;
      checkOutput("rst_valid", 32'(dut_valid), 32'd0);
      checkOutput("rst_sum",   32'(sum),       32'd0);
      checkOutput("rst_flags", 32'({carry, ovf, zero, neg}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("rst_ready", 32'(dut_ready), 32'd1);

      // T1 add
      applyStimulus(16'h1234, 16'h0FCC, 1'b0, 1'b0, 1'b0, lat);
      checkResult("t1_add", 16'h2200, 1'b0, 1'b0, 1'b0, 1'b0, lat);
      consumeResult("t1", 16'h2200);

      // T2 subtraction with borrow, and equal operands
      applyStimulus(16'h0000, 16'h0001, 1'b1, 1'b0, 1'b0, lat);
      checkResult("t2_borrow", 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1, lat);
      consumeResult("t2a", 16'hFFFF);
      applyStimulus(16'h0005, 16'h0005, 1'b1, 1'b0, 1'b0, lat);
      checkResult("t2_equal", 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, lat);
      consumeResult("t2b", 16'h0000);

      // T3 signed overflow and unsigned wrap
      applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, lat);
      checkResult("t3_pos_ovf", 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1, lat);
      consumeResult("t3a", 16'h8000);
      applyStimulus(16'h8000, 16'h0001, 1'b1, 1'b0, 1'b0, lat);
      checkResult("t3_neg_ovf", 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0, lat);
      consumeResult("t3b", 16'h7FFF);
      applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, lat);
      checkResult("t3_wrap", 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, lat);
      consumeResult("t3c", 16'h0000);

      // T4 explicit carry-in chaining
      applyStimulus(16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b1, lat);
      checkResult("t4_cin_add", 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, lat);
      consumeResult("t4a", 16'h0000);
      applyStimulus(16'h0010, 16'h0001, 1'b1, 1'b0, 1'b1, lat);
      checkResult("t4_borrow_in", 16'h000E, 1'b1, 1'b0, 1'b0, 1'b0, lat);
      consumeResult("t4b", 16'h000E);

      // T5 backpressure: hold the result while a stray request is presented
      applyStimulus(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, lat);
      checkResult("t5_first", 16'h3333, 1'b0, 1'b0, 1'b0, 1'b0, lat);
      for (int i = 0; i < 5; i++) begin
         req_valid = 1'b1; a = 16'hAAAA; b = 16'h5555; mode = 1'b1;
         @(posedge clk);
         @(negedge clk);
         checkOutput("t5_hold_valid", 32'(dut_valid), 32'd1);
         checkOutput("t5_hold_ready", 32'(dut_ready), 32'd0);
         checkOutput("t5_hold_sum",   32'(sum),       32'h3333);
      end
      a = 16'h0003; b = 16'h0004; mode = 1'b0; cin = 1'b0; use_cin = 1'b0;
      res_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      res_ready = 1'b0;
      checkOutput("t5_release_valid", 32'(dut_valid), 32'd0);
      checkOutput("t5_release_ready", 32'(dut_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      checkOutput("t5_next_accepted", 32'(dut_ready), 32'd0);
      lat = 0;
      while (!dut_valid && lat < 20) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      checkResult("t5_next", 16'h0007, 1'b0, 1'b0, 1'b0, 1'b0, lat);
      consumeResult("t5", 16'h0007);

      // T6 asynchronous reset while slice 2 is being processed
      a = 16'h00FF; b = 16'h0101; mode = 1'b0; req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("t6_rst_valid", 32'(dut_valid), 32'd0);
      checkOutput("t6_rst_sum",   32'(sum),       32'd0);
      checkOutput("t6_rst_flags", 32'({carry, ovf, zero, neg}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("t6_ready_after", 32'(dut_ready), 32'd1);
      applyStimulus(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, lat);
      checkResult("t6_fresh", 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, lat);

      // Single-slice instance: 0x9 - 0x3 in one cycle
      @(negedge clk);
      checkOutput("small_ready", 32'(s_ready), 32'd1);
      s_a = 4'h9; s_b = 4'h3; s_mode = 1'b1; s_req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      s_req_valid = 1'b0; s_a = 4'h0; s_b = 4'hF; s_mode = 1'b0;
      lat = 0;
      while (!s_valid && lat < 20) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      checkOutput("small_latency", 32'(lat),     32'd1);
      checkOutput("small_sum",     32'(s_sum),   32'h6);
      checkOutput("small_carry",   32'(s_carry), 32'd1);
      checkOutput("small_ovf",     32'(s_ovf),   32'd1);
      checkOutput("small_zero",    32'(s_zero),  32'd0);
      checkOutput("small_neg",     32'(s_neg),   32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
